// File: rtl/bp_ethernet_pkg.sv
// Shared Ethernet definitions for the NIC TX and RX frame paths.
package bp_ethernet_pkg;

    // Largest frame either path must hold (VLAN-tagged 1518 + 4).
    localparam int max_frame_bytes_c = 1522;

    // Size header word that precedes every frame on the frame-data stream.
    typedef struct packed {
        logic [44:0] reserved;
        logic [2:0]  head_offset;
        logic [15:0] size;
    } eth_frame_hdr_s;

    typedef enum logic [1:0] {
        e_rx_recv    = 2'b00,
        e_rx_size    = 2'b01,
        e_rx_payload = 2'b10,
        e_rx_drop    = 2'b11
    } eth_rx_state_e;

    typedef enum logic [1:0] {
        e_tx_idle    = 2'b00,
        e_tx_size    = 2'b01,
        e_tx_payload = 2'b10
    } eth_tx_state_e;

    // Valid bytes in a contiguous-from-bit-0 tkeep: 8 when all ones,
    // otherwise the index of the lowest zero bit.
    function automatic logic [3:0] keep_to_bytes(input logic [7:0] keep);
        logic [3:0] n;
        n = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (!keep[i]) n = 4'(i);
        end
        return n;
    endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One write port, one asynchronous read port register-file memory.
module bsg_mem_1r1w #(
    parameter int width_p = 64,
    parameter int els_p   = 256,
    parameter int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    // Synchronous write; storage is not reset, only written words are read.
    always_ff @(posedge clk_i) begin
        if (w_v_i) mem_r[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/from_rx_axis.sv
// Buffers one AXIS RX frame, then replays it as a size header plus payload words.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RX_RECV    | accepting beats into the buffer, counting bytes
// RX_SIZE    | presenting the size header word
// RX_PAYLOAD | presenting buffered words, one per handshake
// RX_DROP    | frame overflowed the buffer; swallow beats until tlast
module from_rx_axis
    import bp_ethernet_pkg::*;
#(
    parameter int axis_data_width_p = 64,
    parameter int buffer_words_p    = 256
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [axis_data_width_p-1:0]   rx_axis_tdata_i,
    input  logic [axis_data_width_p/8-1:0] rx_axis_tkeep_i,
    input  logic                           rx_axis_tvalid_i,
    output logic                           rx_axis_tready_o,
    input  logic                           rx_axis_tlast_i,
    input  logic                           rx_axis_tuser_i,
    output logic [63:0]                    frame_data_o,
    output logic                           frame_data_v_o,
    input  logic                           frame_data_ready_i,
    output logic                           frame_drop_o,
    output logic [1:0]                     rx_ext_state_o
);

    localparam logic [1:0] RX_RECV    = 2'b00;
    localparam logic [1:0] RX_SIZE    = 2'b01;
    localparam logic [1:0] RX_PAYLOAD = 2'b10;
    localparam logic [1:0] RX_DROP    = 2'b11;

    localparam int ptr_width_lp  = $clog2(buffer_words_p + 1);
    localparam int addr_width_lp = $clog2(buffer_words_p);

    if (axis_data_width_p != 64) begin : g_bad_width
        $error("from_rx_axis supports only 64-bit AXIS data");
    end
    if (buffer_words_p * 8 > 65535) begin : g_bad_depth
        $error("from_rx_axis buffer too deep for a 16-bit byte count");
    end
    if (buffer_words_p * 8 < max_frame_bytes_c) begin : g_small_depth
        $error("from_rx_axis buffer smaller than the max frame");
    end

    logic [1:0]                   state_r;
    logic [ptr_width_lp-1:0]      wr_ptr_r;
    logic [ptr_width_lp-1:0]      rd_ptr_r;
    logic [15:0]                  byte_cnt_r;
    logic                         drop_r;
    logic                         beat_accept;
    logic                         buf_full;
    logic                         buf_we;
    logic                         last_word;
    logic                         out_xfer;
    logic [15:0]                  final_size;
    logic [axis_data_width_p-1:0] rd_data;
    eth_frame_hdr_s               hdr;

    assign rx_axis_tready_o = (state_r == RX_RECV) || (state_r == RX_DROP);
    assign beat_accept      = rx_axis_tvalid_i & rx_axis_tready_o;
    assign buf_full         = (wr_ptr_r == ptr_width_lp'(buffer_words_p));
    assign buf_we           = (state_r == RX_RECV) & beat_accept & ~buf_full;
    assign final_size       = byte_cnt_r + 16'(keep_to_bytes(rx_axis_tkeep_i));
    assign last_word        = (rd_ptr_r == (wr_ptr_r - 1'b1));
    assign frame_data_v_o   = (state_r == RX_SIZE) || (state_r == RX_PAYLOAD);
    assign out_xfer         = frame_data_v_o & frame_data_ready_i;
    assign frame_drop_o     = drop_r;
    assign rx_ext_state_o   = state_r;

    bsg_mem_1r1w #(
        .width_p(axis_data_width_p),
        .els_p  (buffer_words_p)
    ) frame_buf (
        .clk_i   (clk_i),
        .w_v_i   (buf_we),
        .w_addr_i(wr_ptr_r[addr_width_lp-1:0]),
        .w_data_i(rx_axis_tdata_i),
        .r_addr_i(rd_ptr_r[addr_width_lp-1:0]),
        .r_data_o(rd_data)
    );

    // Header word: the RX side always lands frames at head offset 0.
    always_comb begin
        hdr      = '0;
        hdr.size = byte_cnt_r;
        frame_data_o = (state_r == RX_SIZE) ? hdr : rd_data;
    end

    // Frame receive / replay sequencing.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= RX_RECV;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            byte_cnt_r <= '0;
            drop_r     <= 1'b0;
        end else begin
            drop_r <= 1'b0;
            case (state_r)
                RX_RECV: begin
                    if (beat_accept) begin
                        if (buf_full) begin
                            if (rx_axis_tlast_i) begin
                                drop_r     <= 1'b1;
                                wr_ptr_r   <= '0;
                                rd_ptr_r   <= '0;
                                byte_cnt_r <= '0;
                            end else begin
                                state_r <= RX_DROP;
                            end
                        end else if (!rx_axis_tlast_i) begin
                            wr_ptr_r   <= wr_ptr_r + 1'b1;
                            byte_cnt_r <= byte_cnt_r + 16'd8;
                        end else if (rx_axis_tuser_i || (final_size == 16'd0)) begin
                            drop_r     <= 1'b1;
                            wr_ptr_r   <= '0;
                            rd_ptr_r   <= '0;
                            byte_cnt_r <= '0;
                        end else begin
                            wr_ptr_r   <= wr_ptr_r + 1'b1;
                            byte_cnt_r <= final_size;
                            state_r    <= RX_SIZE;
                        end
                    end
                end
                RX_DROP: begin
                    if (beat_accept && rx_axis_tlast_i) begin
                        drop_r     <= 1'b1;
                        wr_ptr_r   <= '0;
                        rd_ptr_r   <= '0;
                        byte_cnt_r <= '0;
                        state_r    <= RX_RECV;
                    end
                end
                RX_SIZE: begin
                    if (out_xfer) begin
                        rd_ptr_r <= '0;
                        state_r  <= RX_PAYLOAD;
                    end
                end
                default: begin
                    if (out_xfer) begin
                        if (last_word) begin
                            wr_ptr_r   <= '0;
                            rd_ptr_r   <= '0;
                            byte_cnt_r <= '0;
                            state_r    <= RX_RECV;
                        end else begin
                            rd_ptr_r <= rd_ptr_r + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Interior beats must carry all eight bytes; the last beat's keep must be contiguous.
    a_nonlast_keep: assert property (@(posedge clk_i) disable iff (reset_i)
        (beat_accept && !rx_axis_tlast_i) |-> (rx_axis_tkeep_i == '1));
    a_last_keep_contig: assert property (@(posedge clk_i) disable iff (reset_i)
        (beat_accept && rx_axis_tlast_i) |-> ((rx_axis_tkeep_i & (rx_axis_tkeep_i + 1'b1)) == '0));

endmodule
